control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer
// Microstep sequencer for a small bus-based CPU. A five-step counter (T0..T4)
// walks each instruction; the control lines are decoded combinationally from
// the current step, the opcode and the flags so that the selected registers
// load on the clock edge that ends the step. HLT freezes the sequencer until
// reset.

module control_sequencer (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic [3:0] OPCODE,
    input  logic       FLAG_C,
    input  logic       FLAG_Z,
    output logic [2:0] STEP,
    output logic       HALTED,
    output logic       MIn,
    output logic       RIn,
    output logic       ROn,
    output logic       IIn,
    output logic       IOn,
    output logic       AIn,
    output logic       AOn,
    output logic       BIn,
    output logic       EOn,
    output logic       OIn,
    output logic       COn,
    output logic       Jn,
    output logic       FIn,
    output logic       SU,
    output logic       CE
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    // Control lines in active-high form; polarity is fixed at the ports.
    typedef struct packed {
        logic mi;
        logic ri;
        logic ro;
        logic ii;
        logic io;
        logic ai;
        logic ao;
        logic bi;
        logic eo;
        logic oi;
        logic co;
        logic j;
        logic fi;
        logic su;
        logic ce;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{default: 1'b0};

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    step_t step_r;
    logic  halted_r;
    logic  halt_s;
    ctl_t  ctl_s;

    // HLT takes effect on the edge that ends its T2 step.
    assign halt_s = (step_r == T2) && (OPCODE == OP_HLT);

    // Step counter and halt latch; out-of-range step values fall back to T0.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            step_r   <= T0;
            halted_r <= 1'b0;
        end else if (halted_r) begin
            step_r   <= step_r;
            halted_r <= 1'b1;
        end else if (halt_s) begin
            step_r   <= T3;
            halted_r <= 1'b1;
        end else begin
            halted_r <= 1'b0;
            case (step_r)
                T0:      step_r <= T1;
                T1:      step_r <= T2;
                T2:      step_r <= T3;
                T3:      step_r <= T4;
                T4:      step_r <= T0;
                default: step_r <= T0;
            endcase
        end
    end

    // Microcode decode; everything idles during reset or while halted.
    always_comb begin
        ctl_s = CTL_IDLE;
        if (RESETn && !halted_r) begin
            case (step_r)
                T0: begin
                    ctl_s.co = 1'b1;
                    ctl_s.mi = 1'b1;
                end
                T1: begin
                    ctl_s.ro = 1'b1;
                    ctl_s.ii = 1'b1;
                    ctl_s.ce = 1'b1;
                end
                T2: begin
                    case (OPCODE)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ctl_s.io = 1'b1;
                            ctl_s.mi = 1'b1;
                        end
                        OP_LDI: begin
                            ctl_s.io = 1'b1;
                            ctl_s.ai = 1'b1;
                        end
                        OP_JMP: begin
                            ctl_s.io = 1'b1;
                            ctl_s.j  = 1'b1;
                        end
                        OP_JC: begin
                            if (FLAG_C) begin
                                ctl_s.io = 1'b1;
                                ctl_s.j  = 1'b1;
                            end else begin
                                ctl_s = CTL_IDLE;
                            end
                        end
                        OP_JZ: begin
                            if (FLAG_Z) begin
                                ctl_s.io = 1'b1;
                                ctl_s.j  = 1'b1;
                            end else begin
                                ctl_s = CTL_IDLE;
                            end
                        end
                        OP_OUT: begin
                            ctl_s.ao = 1'b1;
                            ctl_s.oi = 1'b1;
                        end
                        default: ctl_s = CTL_IDLE;
                    endcase
                end
                T3: begin
                    case (OPCODE)
                        OP_LDA: begin
                            ctl_s.ro = 1'b1;
                            ctl_s.ai = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctl_s.ro = 1'b1;
                            ctl_s.bi = 1'b1;
                        end
                        OP_STA: begin
                            ctl_s.ao = 1'b1;
                            ctl_s.ri = 1'b1;
                        end
                        default: ctl_s = CTL_IDLE;
                    endcase
                end
                T4: begin
                    case (OPCODE)
                        OP_ADD, OP_SUB: begin
                            ctl_s.eo = 1'b1;
                            ctl_s.ai = 1'b1;
                            ctl_s.fi = 1'b1;
                            ctl_s.su = (OPCODE == OP_SUB);
                        end
                        default: ctl_s = CTL_IDLE;
                    endcase
                end
                default: ctl_s = CTL_IDLE;
            endcase
        end else begin
            ctl_s = CTL_IDLE;
        end
    end

    assign STEP   = step_r;
    assign HALTED = halted_r;

    assign MIn = ~ctl_s.mi;
    assign RIn = ~ctl_s.ri;
    assign ROn = ~ctl_s.ro;
    assign IIn = ~ctl_s.ii;
    assign IOn = ~ctl_s.io;
    assign AIn = ~ctl_s.ai;
    assign AOn = ~ctl_s.ao;
    assign BIn = ~ctl_s.bi;
    assign EOn = ~ctl_s.eo;
    assign OIn = ~ctl_s.oi;
    assign COn = ~ctl_s.co;
    assign Jn  = ~ctl_s.j;
    assign FIn = ~ctl_s.fi;
    assign SU  = ctl_s.su;
    assign CE  = ctl_s.ce;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a microcode-table reference
// model plus a step/halt tracker, driven with randomized opcodes and flags.

module tb_control_sequencer;

    logic       CLK    = 1'b0;
    logic       RESETn = 1'b1;
    logic [3:0] OPCODE = 4'h0;
    logic       FLAG_C = 1'b0;
    logic       FLAG_Z = 1'b0;
    logic [2:0] STEP;
    logic       HALTED;
    logic MIn, RIn, ROn, IIn, IOn, AIn, AOn, BIn, EOn, OIn, COn, Jn, FIn, SU, CE;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: current microstep and halt status.
    int m_step = 0;
    bit m_halt = 1'b0;

    // Active-high microcode table, bit order matches got_ctl().
    localparam int B_MI = 14, B_RI = 13, B_RO = 12, B_II = 11, B_IO = 10;
    localparam int B_AI = 9,  B_AO = 8,  B_BI = 7,  B_EO = 6,  B_OI = 5;
    localparam int B_CO = 4,  B_J  = 3,  B_FI = 2,  B_SU = 1,  B_CE = 0;
    localparam logic [14:0] INV  = 15'h7FFC;  // low-active lines (bits 14..2)
    logic [14:0] ucode [16][5];

    always #5 CLK = ~CLK;

    control_sequencer dut (
        .CLK(CLK), .RESETn(RESETn), .OPCODE(OPCODE), .FLAG_C(FLAG_C), .FLAG_Z(FLAG_Z),
        .STEP(STEP), .HALTED(HALTED),
        .MIn(MIn), .RIn(RIn), .ROn(ROn), .IIn(IIn), .IOn(IOn), .AIn(AIn), .AOn(AOn),
        .BIn(BIn), .EOn(EOn), .OIn(OIn), .COn(COn), .Jn(Jn), .FIn(FIn), .SU(SU), .CE(CE)
    );

    function automatic logic [14:0] b(input int i);
        logic [14:0] one = 15'd1;
        return one << i;
    endfunction

    function automatic logic [14:0] got_ctl();
        return {MIn, RIn, ROn, IIn, IOn, AIn, AOn, BIn, EOn, OIn, COn, Jn, FIn, SU, CE};
    endfunction

    task automatic init_model();
        for (int op = 0; op < 16; op++) begin
            for (int s = 0; s < 5; s++) ucode[op][s] = 15'd0;
            ucode[op][0] = b(B_CO) | b(B_MI);
            ucode[op][1] = b(B_RO) | b(B_II) | b(B_CE);
        end
        ucode[1][2] = b(B_IO) | b(B_MI);  ucode[1][3] = b(B_RO) | b(B_AI);
        for (int op = 2; op <= 3; op++) begin
            ucode[op][2] = b(B_IO) | b(B_MI);
            ucode[op][3] = b(B_RO) | b(B_BI);
            ucode[op][4] = b(B_EO) | b(B_AI) | b(B_FI);
        end
        ucode[3][4] = ucode[3][4] | b(B_SU);
        ucode[4][2] = b(B_IO) | b(B_MI);  ucode[4][3] = b(B_AO) | b(B_RI);
        ucode[5][2] = b(B_IO) | b(B_AI);
        ucode[6][2] = b(B_IO) | b(B_J);
        ucode[7][2] = b(B_IO) | b(B_J);
        ucode[8][2] = b(B_IO) | b(B_J);
        ucode[14][2] = b(B_AO) | b(B_OI);
    endtask

    // Expected port-level control vector for a given situation.
    function automatic logic [14:0] exp_ctl(input int st, input logic [3:0] op,
                                            input bit c, input bit z, input bit h, input bit rn);
        logic [14:0] a;
        if (!rn || h || st > 4) a = 15'd0;
        else a = ucode[op][st];
        if (st == 2 && ((op == 4'h7 && !c) || (op == 4'h8 && !z))) a = 15'd0;
        return a ^ INV;
    endfunction

    function automatic logic [18:0] exp_all();
        return {3'(m_step), m_halt, exp_ctl(m_step, OPCODE, FLAG_C, FLAG_Z, m_halt, RESETn)};
    endfunction

    // Wait for a rising edge, advance the model, then settle away from the edge.
    task automatic tick();
        @(posedge CLK);
        if (RESETn && !m_halt) begin
            if (m_step == 2 && OPCODE == 4'hF) begin
                m_halt = 1'b1;
                m_step = 3;
            end else begin
                m_step = (m_step + 1) % 5;
            end
        end
        #2;
    endtask

    task automatic do_reset();
        RESETn = 1'b0;
        #3;
        m_step = 0;
        m_halt = 1'b0;
        RESETn = 1'b1;
    endtask

    task automatic test_reset();
        #1 RESETn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            OPCODE = 4'($urandom());
            FLAG_C = 1'($urandom());
            FLAG_Z = 1'($urandom());
            #1;
            n_cmp++;
            if ({STEP, HALTED, got_ctl()} !== {3'd0, 1'b0, INV}) begin
                n_bad++;
                $display("FAIL reset_hold got=%h exp=%h", {STEP, HALTED, got_ctl()}, {3'd0, 1'b0, INV});
            end
            tick();
        end
        m_step = 0;
        m_halt = 1'b0;
        RESETn = 1'b1;
        #1;
        n_cmp++;
        if ({STEP, HALTED, got_ctl()} !== exp_all()) begin
            n_bad++;
            $display("FAIL reset_release got=%h exp=%h", {STEP, HALTED, got_ctl()}, exp_all());
        end
        tick();
        n_cmp++;
        if (STEP !== 3'd1) begin
            n_bad++;
            $display("FAIL first_edge_step got=%0d exp=1", STEP);
        end
    endtask

    task automatic test_nop_run();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            OPCODE = 4'h0;
            FLAG_C = 1'($urandom());
            FLAG_Z = 1'($urandom());
            #1;
            n_cmp++;
            if (STEP !== 3'(i % 5)) begin
                n_bad++;
                $display("FAIL nop_step i=%0d got=%0d exp=%0d", i, STEP, i % 5);
            end
            n_cmp++;
            if ({COn, MIn, ROn, IIn, CE} !== {(i % 5 == 0) ? 2'b00 : 2'b11,
                                              (i % 5 == 1) ? 3'b001 : 3'b110}) begin
                n_bad++;
                $display("FAIL nop_fetch i=%0d got=%b", i, {COn, MIn, ROn, IIn, CE});
            end
            n_cmp++;
            if ({STEP, HALTED, got_ctl()} !== exp_all()) begin
                n_bad++;
                $display("FAIL nop_ctl i=%0d got=%h exp=%h", i, {STEP, HALTED, got_ctl()}, exp_all());
            end
            tick();
        end
    endtask

    task automatic test_sub();
        do_reset();
        OPCODE = 4'h3;
        for (int s = 0; s < 5; s++) begin
            FLAG_C = 1'($urandom());
            FLAG_Z = 1'($urandom());
            #1;
            n_cmp++;
            if ({STEP, HALTED, got_ctl()} !== exp_all()) begin
                n_bad++;
                $display("FAIL sub_ctl s=%0d got=%h exp=%h", s, {STEP, HALTED, got_ctl()}, exp_all());
            end
            n_cmp++;
            if (SU !== (s == 4)) begin
                n_bad++;
                $display("FAIL sub_su s=%0d got=%b exp=%b", s, SU, s == 4);
            end
            tick();
        end
    endtask

    task automatic test_cond_jumps();
        for (int k = 0; k < 4; k++) begin
            bit f = 1'(k % 2);
            do_reset();
            OPCODE = (k < 2) ? 4'h7 : 4'h8;
            for (int s = 0; s < 5; s++) begin
                FLAG_C = 1'($urandom());
                FLAG_Z = 1'($urandom());
                if (s == 2) begin
                    if (k < 2) FLAG_C = f;
                    else FLAG_Z = f;
                end
                #1;
                n_cmp++;
                if ({STEP, HALTED, got_ctl()} !== exp_all()) begin
                    n_bad++;
                    $display("FAIL jump_ctl op=%h f=%0d s=%0d got=%h exp=%h", OPCODE, f, s,
                             {STEP, HALTED, got_ctl()}, exp_all());
                end
                if (s == 2) begin
                    n_cmp++;
                    if ({Jn, IOn} !== (f ? 2'b00 : 2'b11)) begin
                        n_bad++;
                        $display("FAIL jump_t2 op=%h f=%0d got=%b", OPCODE, f, {Jn, IOn});
                    end
                end else begin
                    FLAG_C = ~FLAG_C;
                    FLAG_Z = ~FLAG_Z;
                    #1;
                    n_cmp++;
                    if ({STEP, HALTED, got_ctl()} !== exp_all()) begin
                        n_bad++;
                        $display("FAIL jump_toggle op=%h s=%0d got=%h exp=%h", OPCODE, s,
                                 {STEP, HALTED, got_ctl()}, exp_all());
                    end
                end
                tick();
            end
        end
    endtask

    task automatic test_halt();
        do_reset();
        OPCODE = 4'hF;
        for (int s = 0; s < 3; s++) begin
            #1;
            n_cmp++;
            if ({STEP, HALTED, got_ctl()} !== exp_all()) begin
                n_bad++;
                $display("FAIL hlt_pre s=%0d got=%h exp=%h", s, {STEP, HALTED, got_ctl()}, exp_all());
            end
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            OPCODE = 4'($urandom());
            FLAG_C = 1'($urandom());
            FLAG_Z = 1'($urandom());
            #1;
            n_cmp++;
            if ({STEP, HALTED, got_ctl()} !== {3'd3, 1'b1, INV}) begin
                n_bad++;
                $display("FAIL hlt_frozen i=%0d got=%h exp=%h", i, {STEP, HALTED, got_ctl()},
                         {3'd3, 1'b1, INV});
            end
            tick();
        end
        RESETn = 1'b0;
        #1;
        n_cmp++;
        if ({STEP, HALTED} !== 4'b0000) begin
            n_bad++;
            $display("FAIL hlt_reset got=%b exp=0000", {STEP, HALTED});
        end
        m_step = 0;
        m_halt = 1'b0;
        #1 RESETn = 1'b1;
    endtask

    task automatic test_sta_reset();
        do_reset();
        OPCODE = 4'h4;
        for (int s = 0; s < 3; s++) tick();
        #1;
        n_cmp++;
        if ({STEP, RIn, AOn} !== {3'd3, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL sta_t3 got=%b exp=01100", {STEP, RIn, AOn});
        end
        #1 RESETn = 1'b0;
        #1;
        n_cmp++;
        if ({STEP, HALTED, got_ctl()} !== {3'd0, 1'b0, INV}) begin
            n_bad++;
            $display("FAIL sta_async got=%h exp=%h", {STEP, HALTED, got_ctl()}, {3'd0, 1'b0, INV});
        end
        m_step = 0;
        m_halt = 1'b0;
        RESETn = 1'b1;
        #1;
        n_cmp++;
        if ({STEP, COn, MIn, RIn} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL sta_restart got=%b exp=000001", {STEP, COn, MIn, RIn});
        end
        tick();
        n_cmp++;
        if ({STEP, HALTED, got_ctl()} !== exp_all()) begin
            n_bad++;
            $display("FAIL sta_fetch got=%h exp=%h", {STEP, HALTED, got_ctl()}, exp_all());
        end
    endtask

    task automatic test_sweep();
        for (int op = 0; op < 16; op++) begin
            do_reset();
            OPCODE = 4'(op);
            for (int s = 0; s < 5; s++) begin
                for (int fc = 0; fc < 4; fc++) begin
                    FLAG_C = 1'(fc >> 1);
                    FLAG_Z = 1'(fc);
                    #1;
                    n_cmp++;
                    if ($countones(~{ROn, IOn, AOn, EOn, COn}) > 1) begin
                        n_bad++;
                        $display("FAIL bus_conflict op=%h step=%0d got=%b", OPCODE, STEP,
                                 {ROn, IOn, AOn, EOn, COn});
                    end
                    n_cmp++;
                    if ({STEP, HALTED, got_ctl()} !== exp_all()) begin
                        n_bad++;
                        $display("FAIL sweep op=%h s=%0d fc=%0d got=%h exp=%h", OPCODE, s, fc,
                                 {STEP, HALTED, got_ctl()}, exp_all());
                    end
                    if (op >= 9 && op <= 13) begin
                        n_cmp++;
                        if (got_ctl() !== exp_ctl(m_step, 4'h0, FLAG_C, FLAG_Z, m_halt, RESETn)) begin
                            n_bad++;
                            $display("FAIL as_nop op=%h s=%0d got=%h", OPCODE, s, got_ctl());
                        end
                    end
                end
                tick();
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            OPCODE = 4'($urandom());
            FLAG_C = 1'($urandom());
            FLAG_Z = 1'($urandom());
            #1;
            n_cmp++;
            if ({STEP, HALTED, got_ctl()} !== exp_all()) begin
                n_bad++;
                $display("FAIL random i=%0d got=%h exp=%h", i, {STEP, HALTED, got_ctl()}, exp_all());
            end
            if ($urandom_range(39, 0) == 0) begin
                RESETn = 1'b0;
                #1;
                m_step = 0;
                m_halt = 1'b0;
                n_cmp++;
                if ({STEP, HALTED, got_ctl()} !== exp_all()) begin
                    n_bad++;
                    $display("FAIL random_rst i=%0d got=%h exp=%h", i, {STEP, HALTED, got_ctl()},
                             exp_all());
                end
                RESETn = 1'b1;
            end
            tick();
        end
    endtask

    initial begin
        init_model();
        test_reset();
        test_nop_run();
        test_sub();
        test_cond_jumps();
        test_halt();
        test_sta_reset();
        test_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
